// File: rtl/writeback_cache.sv
// Direct-mapped, write-back, write-allocate cache in front of a 64-bit burst RAM.
// Tag/valid/dirty/data are read with one cycle of latency; line fills and evictions are BEATS-long bursts.
module writeback_cache #(
  parameter int LINE_IX_BITWIDTH         = 8,
  parameter int COLUMN_IX_BITWIDTH       = 3,
  parameter int BURST_RAM_DEPTH_BITWIDTH = 21
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic [31:0]                         address,
  input  logic [31:0]                         data_in,
  input  logic [3:0]                          write_enable,
  output logic [31:0]                         data_out,
  output logic                                data_out_ready,
  output logic                                busy,
  output logic                                br_cmd,
  output logic                                br_cmd_en,
  output logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]                         br_wr_data,
  output logic [7:0]                          br_data_mask,
  input  logic [63:0]                         br_rd_data,
  input  logic                                br_rd_data_ready,
  input  logic                                br_busy
);
  localparam int LIX        = LINE_IX_BITWIDTH;
  localparam int CIX        = COLUMN_IX_BITWIDTH;
  localparam int BRW        = BURST_RAM_DEPTH_BITWIDTH;
  localparam int LINE_COUNT = 1 << LIX;
  localparam int WORDS      = 1 << CIX;
  localparam int BEATS      = WORDS / 2;
  localparam int TAG_BITWIDTH = 32 - LIX - CIX - 2;
  localparam int LINE_W     = 32 * WORDS;
  localparam int BEAT_W     = (CIX > 2) ? CIX - 1 : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {INIT, IDLE, LOOKUP, EVICT, FETCH_WAIT, FETCH, FILL_DONE} state_t;

  state_t state_q, state_d;
  logic [LIX-1:0]          init_cnt_q;
  logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic                    issued_q, issued_d;
  logic [TAG_BITWIDTH-1:0] req_tag_q, evict_tag_q, rd_tag;
  logic [LIX-1:0]          req_line_q, lookup_ix;
  logic [CIX-1:0]          req_col_q;
  logic [LINE_W-1:0]       rd_line, evict_line_q;
  logic                    rd_valid, rd_dirty, hit;
  logic [31:0]             merged_word;
  logic [31:0]             fetch_full, evict_full;

  logic [TAG_BITWIDTH-1:0] tag_mem  [LINE_COUNT];
  logic [LINE_W-1:0]       data_mem [LINE_COUNT];
  logic [LINE_COUNT-1:0]   valid_q, dirty_q;

  logic latch_req, latch_evict, hit_write, fill_beat, fill_done;

  logic [TAG_BITWIDTH-1:0] a_tag;
  logic [LIX-1:0]          a_line;
  logic [CIX-1:0]          a_col;
  assign a_col  = address[CIX+1:2];
  assign a_line = address[CIX+LIX+1:CIX+2];
  assign a_tag  = address[31:CIX+LIX+2];

  // In IDLE the request is not latched yet, so index the RAMs straight from the port.
  assign lookup_ix  = (state_q == IDLE) ? a_line : req_line_q;
  assign hit        = rd_valid && (rd_tag == req_tag_q);
  assign data_out   = rd_line[32'(req_col_q)*32 +: 32];
  assign fetch_full = {{(CIX+2){1'b0}}, req_tag_q, req_line_q} << (CIX - 1);
  assign evict_full = {{(CIX+2){1'b0}}, evict_tag_q, req_line_q} << (CIX - 1);
  assign br_data_mask = '0;

  logic unused_bits;
  assign unused_bits = ^{address[1:0], fetch_full[31:BRW], evict_full[31:BRW]};

  always_comb begin
    merged_word = rd_line[32'(req_col_q)*32 +: 32];
    for (int unsigned b = 0; b < 4; b++)
      if (write_enable[b]) merged_word[b*8 +: 8] = data_in[b*8 +: 8];
  end

  always_comb begin
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    issued_d       = issued_q;
    br_cmd         = 1'b0;
    br_cmd_en      = 1'b0;
    br_addr        = '0;
    br_wr_data     = '0;
    busy           = 1'b1;
    data_out_ready = 1'b0;
    latch_req      = 1'b0;
    latch_evict    = 1'b0;
    hit_write      = 1'b0;
    fill_beat      = 1'b0;
    fill_done      = 1'b0;
    case (state_q)
      INIT: if (init_cnt_q == '1) state_d = IDLE;
      IDLE: begin
        busy = enable;
        if (enable) begin
          latch_req = 1'b1;
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!enable) begin
          busy    = 1'b0;
          state_d = IDLE;
        end else if (hit) begin
          busy    = 1'b0;
          state_d = IDLE;
          if (write_enable == '0) data_out_ready = 1'b1;
          else                    hit_write      = 1'b1;
        end else if (rd_valid && rd_dirty) begin
          latch_evict = 1'b1;
          beat_cnt_d  = '0;
          state_d     = EVICT;
        end else begin
          issued_d = 1'b0;
          state_d  = FETCH_WAIT;
        end
      end
      EVICT: begin
        br_cmd  = 1'b1;
        br_addr = evict_full[BRW-1:0];
        // Beat 0 rides with the command, so only the first beat waits on br_busy.
        if (beat_cnt_q != '0 || !br_busy) begin
          br_cmd_en  = (beat_cnt_q == '0);
          br_wr_data = evict_line_q[32'(beat_cnt_q)*64 +: 64];
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            issued_d   = 1'b0;
            state_d    = FETCH_WAIT;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      FETCH_WAIT, FETCH: begin
        br_addr = fetch_full[BRW-1:0];
        if (state_q == FETCH_WAIT && !issued_q) begin
          if (!br_busy) begin
            br_cmd_en = 1'b1;
            issued_d  = 1'b1;
          end
        end else if (br_rd_data_ready) begin
          fill_beat = 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = FILL_DONE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            state_d    = FETCH;
          end
        end
      end
      FILL_DONE: begin
        fill_done = 1'b1;
        issued_d  = 1'b0;
        state_d   = LOOKUP;
      end
      default: state_d = INIT;
    endcase
    if (rst) begin
      br_cmd         = 1'b0;
      br_cmd_en      = 1'b0;
      br_addr        = '0;
      br_wr_data     = '0;
      busy           = 1'b1;
      data_out_ready = 1'b0;
      hit_write      = 1'b0;
      fill_beat      = 1'b0;
      fill_done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      beat_cnt_q <= '0;
      issued_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      issued_q   <= issued_d;
      if (state_q == INIT) init_cnt_q <= init_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (latch_req) begin
      req_tag_q  <= a_tag;
      req_line_q <= a_line;
      req_col_q  <= a_col;
    end
    if (latch_evict) begin
      evict_tag_q  <= rd_tag;
      evict_line_q <= rd_line;
    end
    if (state_q == INIT) begin
      valid_q[init_cnt_q] <= 1'b0;
      dirty_q[init_cnt_q] <= 1'b0;
    end
    if (fill_beat) data_mem[req_line_q][32'(beat_cnt_q)*64 +: 64] <= br_rd_data;
    if (fill_done) begin
      tag_mem[req_line_q] <= req_tag_q;
      valid_q[req_line_q] <= 1'b1;
      dirty_q[req_line_q] <= 1'b0;
    end
    if (hit_write) begin
      data_mem[req_line_q][32'(req_col_q)*32 +: 32] <= merged_word;
      dirty_q[req_line_q] <= 1'b1;
    end
    // The tag written in FILL_DONE is forwarded so the following LOOKUP sees the new line.
    rd_tag   <= fill_done ? req_tag_q : tag_mem[lookup_ix];
    rd_valid <= fill_done | valid_q[lookup_ix];
    rd_dirty <= !fill_done & dirty_q[lookup_ix];
    rd_line  <= data_mem[lookup_ix];
  end
endmodule

// File: tb/tb_writeback_cache.sv
// Scoreboard bench for writeback_cache: expected reads, burst commands and eviction beats are queued
// by the stimulus and checked by monitors; a small burst-RAM model answers the DUT.
module tb_writeback_cache;
  logic        clk = 1'b0;
  logic        rst, enable;
  logic [31:0] address, data_in, data_out;
  logic [3:0]  write_enable;
  logic        data_out_ready, busy, br_cmd, br_cmd_en;
  logic [20:0] br_addr;
  logic [63:0] br_wr_data, br_rd_data;
  logic [7:0]  br_data_mask;
  logic        br_rd_data_ready, br_busy;

  always #5 clk = ~clk;

  writeback_cache #(
    .LINE_IX_BITWIDTH(8),
    .COLUMN_IX_BITWIDTH(3),
    .BURST_RAM_DEPTH_BITWIDTH(21)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .address(address), .data_in(data_in),
    .write_enable(write_enable), .data_out(data_out), .data_out_ready(data_out_ready),
    .busy(busy), .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
    .br_wr_data(br_wr_data), .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
    .br_rd_data_ready(br_rd_data_ready), .br_busy(br_busy)
  );

  int errors = 0, checks = 0, cyc = 0;
  int cmd_count = 0, last_cmd_cyc = -1, rd_sent = 0, release_cyc = 0;
  int rd_active = 0, rd_delay = 0, rd_k = 0, rd_base = 0, wr_left = 0, wr_addr = 0;
  logic [31:0] exp_rd[$];
  logic [21:0] exp_cmd[$];
  logic [63:0] exp_wbeat[$];
  logic [63:0] ram [int];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] ram_rd(input int a);
    if (ram.exists(a)) return ram[a];
    return {8'hA1, a[23:0], 8'hA0, a[23:0]};
  endfunction

  task automatic take_wbeat(input logic [63:0] d);
    ram[wr_addr] = d;
    wr_addr++;
    if (exp_wbeat.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_wbeat actual=%h required=none", d);
    end else chk("evict_beat", d, exp_wbeat.pop_front());
  endtask

  // Burst RAM model and command/beat monitor
  always @(negedge clk) begin
    if (rst) begin
      rd_active = 0; wr_left = 0; br_rd_data_ready = 1'b0;
    end else begin
      br_rd_data_ready = 1'b0;
      if (rd_active != 0) begin
        if (rd_delay > 0) rd_delay--;
        else begin
          br_rd_data = ram_rd(rd_base + rd_k);
          br_rd_data_ready = 1'b1;
          rd_k++; rd_sent++;
          if (rd_k == 4) rd_active = 0;
        end
      end
      if (wr_left > 0) begin
        take_wbeat(br_wr_data);
        wr_left--;
      end
      if (br_cmd_en === 1'b1) begin
        cmd_count++;
        last_cmd_cyc = cyc;
        chk("cmd_en_while_br_busy", br_busy, 1'b0);
        if (exp_cmd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd actual=%h required=none", {br_cmd, br_addr});
        end else chk("burst_cmd", {br_cmd, br_addr}, exp_cmd.pop_front());
        if (br_cmd) begin
          wr_addr = int'(br_addr);
          take_wbeat(br_wr_data);
          wr_left = 3;
        end else begin
          rd_active = 1; rd_delay = 2; rd_k = 0; rd_base = int'(br_addr);
        end
      end
    end
  end

  // Read-data monitor
  always @(negedge clk) begin
    if (data_out_ready === 1'b1) begin
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read actual=%h required=none", data_out);
      end else chk("read_data", data_out, exp_rd.pop_front());
    end
  end

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    int n = 0;
    @(posedge clk); #1;
    address = a; data_in = d; write_enable = we; enable = 1'b1;
    @(negedge clk);
    while (busy !== 1'b0 && n < 300) begin n++; @(negedge clk); end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL req_timeout actual=busy required=done addr=%h", a);
    end
    @(posedge clk); #1;
    enable = 1'b0; write_enable = '0;
  endtask

  task automatic wait_init();
    int n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 1000) begin n++; @(negedge clk); end
    chk("init_busy_cycles", n, 256);
  endtask

  task automatic exp_evict(input logic [20:0] a, input logic [63:0] b0, input logic [63:0] b1,
                           input logic [63:0] b2, input logic [63:0] b3);
    exp_cmd.push_back({1'b1, a});
    exp_wbeat.push_back(b0); exp_wbeat.push_back(b1);
    exp_wbeat.push_back(b2); exp_wbeat.push_back(b3);
  endtask

  initial begin
    int c0, base, n;
    rst = 1'b1; enable = 1'b0; address = '0; data_in = '0; write_enable = '0;
    br_busy = 1'b0; br_rd_data = '0; br_rd_data_ready = 1'b0;

    @(posedge clk); @(negedge clk);
    chk("rst_busy", busy, 1'b1);
    chk("rst_cmd_en", br_cmd_en, 1'b0);
    chk("rst_data_ready", data_out_ready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    wait_init();
    chk("init_no_cmd", cmd_count, 0);

    // cold read miss
    exp_cmd.push_back({1'b0, 21'h4});
    exp_rd.push_back(32'hA100_0004);
    do_req(32'h0000_0024, '0, 4'b0000);

    // write hits and read-backs, no bursts
    c0 = cmd_count;
    do_req(32'h0000_0024, 32'hDEAD_BEEF, 4'b0011);
    do_req(32'h0000_0038, 32'hCAFE_0000, 4'b1100);
    exp_rd.push_back(32'hA100_BEEF); do_req(32'h0000_0024, '0, 4'b0000);
    exp_rd.push_back(32'hA000_0004); do_req(32'h0000_0020, '0, 4'b0000);
    exp_rd.push_back(32'hCAFE_0007); do_req(32'h0000_0038, '0, 4'b0000);
    chk("hit_no_burst", cmd_count, c0);

    // dirty eviction then fetch of the other tag
    exp_evict(21'h4, 64'hA100_BEEF_A000_0004, 64'hA100_0005_A000_0005,
              64'hA100_0006_A000_0006, 64'hA100_0007_CAFE_0007);
    exp_cmd.push_back({1'b0, 21'h404});
    exp_rd.push_back(32'hA100_0404);
    do_req(32'h0000_2024, '0, 4'b0000);

    // written-back line comes back from burst RAM
    exp_cmd.push_back({1'b0, 21'h4});
    exp_rd.push_back(32'hA100_BEEF); do_req(32'h0000_0024, '0, 4'b0000);
    exp_rd.push_back(32'hCAFE_0007); do_req(32'h0000_0038, '0, 4'b0000);

    // backpressure on the fetch command
    exp_cmd.push_back({1'b0, 21'h808});
    exp_rd.push_back(32'hA000_0808);
    br_busy = 1'b1;
    fork
      do_req(32'h0000_4040, '0, 4'b0000);
      begin
        repeat (10) @(posedge clk);
        #1 br_busy = 1'b0;
        release_cyc = cyc;
      end
    join
    chk("bp_cmd_cycle", last_cmd_cyc, release_cyc);

    // write miss allocates, then its eviction carries the written word
    exp_cmd.push_back({1'b0, 21'h8});
    do_req(32'h0000_0040, 32'h1122_3344, 4'b1111);
    exp_rd.push_back(32'h1122_3344); do_req(32'h0000_0040, '0, 4'b0000);
    exp_evict(21'h8, 64'hA100_0008_1122_3344, 64'hA100_0009_A000_0009,
              64'hA100_000A_A000_000A, 64'hA100_000B_A000_000B);
    exp_cmd.push_back({1'b0, 21'h808});
    exp_rd.push_back(32'hA000_0808);
    do_req(32'h0000_4040, '0, 4'b0000);

    // reset in the middle of a fetch
    exp_cmd.push_back({1'b0, 21'hC0C});
    base = rd_sent;
    @(posedge clk); #1;
    address = 32'h0000_6060; write_enable = '0; enable = 1'b1;
    n = 0;
    while (rd_sent < base + 2 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL midfetch_timeout actual=%0d required=%0d beats", rd_sent - base, 2);
    end
    @(posedge clk); #1;
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    chk("midrst_cmd_en", br_cmd_en, 1'b0);
    chk("midrst_br_addr", br_addr, 21'h0);
    chk("midrst_busy", busy, 1'b1);
    chk("midrst_data_ready", data_out_ready, 1'b0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    wait_init();
    exp_cmd.push_back({1'b0, 21'hC0C});
    exp_rd.push_back(32'hA000_0C0C);
    do_req(32'h0000_6060, '0, 4'b0000);

    repeat (3) @(negedge clk);
    chk("left_reads", exp_rd.size(), 0);
    chk("left_cmds", exp_cmd.size(), 0);
    chk("left_wbeats", exp_wbeat.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
